branch_redirect_arb: RTL and testbench
======================================

# branch_redirect_arb

Collects mispredict writebacks from all branch-capable functional units in the same cycle and keeps the oldest one in a single buffered slot. It drives that slot to the frontend/FTQ as a redirect with a valid/ready handshake. It also pulses a backend squash for all instructions younger than the mispredicted branch. It filters later wrong-path mispredicts until the redirecting branch commits or a global flush occurs.

## Interface
Parameters:
- NBRU, 2, number of branch writeback ports
- ROBW, 6, ROB index bits excluding wrap bit; rob_idx is {wrap, idx[ROBW-1:0]}

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_flush  in  1  global flush from commit (exception/interrupt)
- i_branchwb_vld  in  NBRU  per-port mispredict writeback valid
- i_branchwbInfo  in  NBRU x branchwbInfo_t  per-port payload (branch_type, rob_idx, ftq_idx, has_mispred, branch_taken, fallthruOffset, target_pc, branch_npc)
- i_commit_vld  in  1  ROB committed an instruction this cycle
- i_commit_rob_idx  in  ROBW+1  rob_idx of that instruction
- o_redirect_vld  out  1  redirect slot valid
- i_redirect_rdy  in  1  frontend accepts redirect
- o_redirect_info  out  branchwbInfo_t  slot payload; frontend uses ftq_idx and branch_npc
- o_squash_vld  out  1  one-cycle squash pulse
- o_squash_rob_idx  out  ROBW+1  squash everything strictly younger than this

## Operation
- Age: a older than b iff (a.wrap==b.wrap) ? a.idx<b.idx : a.idx>b.idx.
- Candidate select (combinational): among ports with vld=1, pick the oldest rob_idx. Ties go to the lower port index; equal rob_idx across ports is an assertion failure.
- Barrier filter: a candidate is dropped if barrier_vld and the candidate is not older than barrier_idx.
- Slot update, in priority order:
  1. i_flush: clear slot, barrier and squash; that cycle's inputs are dropped.
  2. A surviving candidate loads the slot and barrier when the slot is empty or the candidate is older than the slot. This holds even if the current slot is handshaking this cycle (replacement wins).
  3. Otherwise, if o_redirect_vld&&i_redirect_rdy, the slot clears.
  4. Otherwise the slot holds.
- On every slot load: o_squash_vld=1 next cycle, with o_squash_rob_idx=loaded rob_idx. Otherwise o_squash_vld=0.
- Barrier (barrier_vld, barrier_idx) equals the rob_idx of the last loaded slot and survives the handshake.
- Barrier clears when i_commit_vld && i_commit_rob_idx==barrier_idx, or on i_flush. A same-cycle load overrides the commit clear.
- Payload is registered unchanged from the winning port.
- FSM: IDLE (slot empty) and PEND (slot full).
  - IDLE→PEND on load.
  - PEND→IDLE on handshake without load, or on flush.
  - PEND→PEND on replacement or hold.
- Reset values: o_redirect_vld=0, o_squash_vld=0, barrier_vld=0. o_redirect_info and o_squash_rob_idx are 0.

## Timing
- Latency from input valid at edge t to o_redirect_vld/o_squash_vld is 1 cycle (registered, visible after edge t+1).
- o_redirect_info is stable while vld&&!rdy, except on replacement by an older branch. The frontend must tolerate that.
- Throughput is one redirect per cycle. Back-to-back older candidates each produce a squash pulse.
- i_flush has effect after the edge at which it is sampled. The slot is empty the next cycle, even if rdy was high.
- Wrap-around: slot rob_idx {1,3} vs candidate {0,60}. The candidate is older and replaces the slot.

## Test plan
- Single mispredict: port0 vld with rob_idx {0,5}, ftq_idx 2, npc 0x8000_0100; rdy=1. Next cycle: redirect_vld=1 with npc 0x8000_0100, and squash_vld=1 with idx {0,5}. The following cycle redirect_vld=0.
- Same-cycle arbitration: port0 {0,9} and port1 {0,4}. Slot holds {0,4}; one squash at {0,4}.
- Replacement under backpressure: rdy=0 with slot {0,20}. Then port1 {0,12} arrives, giving slot {0,12} and a second squash pulse. A later {0,30} is dropped with no squash.
- Barrier: handshake of {0,12}, then port0 {0,15} is dropped. Commit of {0,12} clears the barrier, after which {0,15} is accepted.
- Wrap compare: slot {1,3}, candidate {0,60}. The candidate wins.
- Flush and reset: i_flush with slot full and a port valid in the same cycle gives slot empty, no squash and barrier clear. rst mid-PEND gives all valids 0 next cycle.

Source files
------------

// File: rtl/branch_redirect_arb_if.sv
// Payload type and the bundled writeback/commit/redirect/squash bus for branch_redirect_arb.
package branch_redirect_arb_pkg;

    localparam int PKG_ROBW = 6;

    typedef struct packed {
        logic [2:0]          branch_type;
        logic [PKG_ROBW:0]   rob_idx;
        logic [3:0]          ftq_idx;
        logic                has_mispred;
        logic                branch_taken;
        logic [3:0]          fallthruOffset;
        logic [31:0]         target_pc;
        logic [31:0]         branch_npc;
    } branchwbInfo_t;

endpackage

interface branch_redirect_arb_if #(
    parameter int NBRU = 2,
    parameter int ROBW = 6
);
    import branch_redirect_arb_pkg::*;

    logic                i_flush;
    logic [NBRU-1:0]     i_branchwb_vld;
    branchwbInfo_t       i_branchwbInfo [NBRU];
    logic                i_commit_vld;
    logic [ROBW:0]       i_commit_rob_idx;
    logic                o_redirect_vld;
    logic                i_redirect_rdy;
    branchwbInfo_t       o_redirect_info;
    logic                o_squash_vld;
    logic [ROBW:0]       o_squash_rob_idx;

    // Backend/frontend side: drives writebacks, commits and the redirect ready.
    modport master (
        output i_flush, i_branchwb_vld, i_branchwbInfo, i_commit_vld, i_commit_rob_idx, i_redirect_rdy,
        input  o_redirect_vld, o_redirect_info, o_squash_vld, o_squash_rob_idx
    );

    // Arbiter side.
    modport slave (
        input  i_flush, i_branchwb_vld, i_branchwbInfo, i_commit_vld, i_commit_rob_idx, i_redirect_rdy,
        output o_redirect_vld, o_redirect_info, o_squash_vld, o_squash_rob_idx
    );

endinterface

// File: rtl/branch_redirect_arb.sv
// Keeps the oldest mispredicting branch in a one-entry redirect slot, pulses a
// squash on every load and filters younger wrong-path mispredicts behind a barrier.
module branch_redirect_arb
    import branch_redirect_arb_pkg::*;
#(
    parameter int NBRU = 2,
    parameter int ROBW = PKG_ROBW
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_redirect_arb_if.slave bus
);

    typedef enum logic { IDLE, PEND } state_t;

    state_t        state_q, state_d;
    branchwbInfo_t slot_q, slot_d;
    logic          bar_vld_q, bar_vld_d;
    logic [ROBW:0] bar_idx_q, bar_idx_d;
    logic          sq_vld_q, sq_vld_d;
    logic [ROBW:0] sq_idx_q, sq_idx_d;

    logic          cand_vld;
    branchwbInfo_t cand;
    logic          cand_ok;
    logic          load;
    logic          dup_rob;

    // a is older than b; the wrap bit flips the sense of the index compare.
    function automatic logic is_older(input logic [ROBW:0] a, input logic [ROBW:0] b);
        if (a[ROBW] == b[ROBW])
            return a[ROBW-1:0] < b[ROBW-1:0];
        else
            return a[ROBW-1:0] > b[ROBW-1:0];
    endfunction

    // Pick the oldest valid writeback; strict compare keeps ties on the lower port.
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        dup_rob  = 1'b0;
        for (int unsigned p = 0; p < NBRU; p++) begin
            if (bus.i_branchwb_vld[p]) begin
                if (!cand_vld || is_older(bus.i_branchwbInfo[p].rob_idx, cand.rob_idx)) begin
                    cand_vld = 1'b1;
                    cand     = bus.i_branchwbInfo[p];
                end
                for (int unsigned q = p + 1; q < NBRU; q++) begin
                    if (bus.i_branchwb_vld[q] &&
                        bus.i_branchwbInfo[q].rob_idx == bus.i_branchwbInfo[p].rob_idx)
                        dup_rob = 1'b1;
                end
            end
        end
    end

    // Barrier filter, load decision and next state of slot/barrier/squash.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        bar_vld_d = bar_vld_q;
        bar_idx_d = bar_idx_q;
        sq_vld_d  = 1'b0;
        sq_idx_d  = sq_idx_q;

        cand_ok = cand_vld && !(bar_vld_q && !is_older(cand.rob_idx, bar_idx_q));
        load    = !bus.i_flush && cand_ok &&
                  (state_q == IDLE || is_older(cand.rob_idx, slot_q.rob_idx));

        if (bus.i_flush) begin
            state_d   = IDLE;
            bar_vld_d = 1'b0;
        end else if (load) begin
            // A replacement wins over a handshake of the old slot in the same cycle.
            state_d   = PEND;
            slot_d    = cand;
            bar_vld_d = 1'b1;
            bar_idx_d = cand.rob_idx;
            sq_vld_d  = 1'b1;
            sq_idx_d  = cand.rob_idx;
        end else begin
            if (state_q == PEND && bus.i_redirect_rdy)
                state_d = IDLE;
            if (bus.i_commit_vld && bus.i_commit_rob_idx == bar_idx_q)
                bar_vld_d = 1'b0;
        end
    end

    // State and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            bar_vld_q <= 1'b0;
            bar_idx_q <= '0;
            sq_vld_q  <= 1'b0;
            sq_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            bar_vld_q <= bar_vld_d;
            bar_idx_q <= bar_idx_d;
            sq_vld_q  <= sq_vld_d;
            sq_idx_q  <= sq_idx_d;
        end
    end

    // Two writeback ports must never report the same ROB entry.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!dup_rob) else $error("branch_redirect_arb: duplicate rob_idx across ports");
    end

    assign bus.o_redirect_vld   = (state_q == PEND);
    assign bus.o_redirect_info  = slot_q;
    assign bus.o_squash_vld     = sq_vld_q;
    assign bus.o_squash_rob_idx = sq_idx_q;

endmodule

// File: tb/tb_branch_redirect_arb.sv
// Directed bench for branch_redirect_arb with a ring-distance reference model.
module tb_branch_redirect_arb;
    import branch_redirect_arb_pkg::*;

    localparam int NBRU = 2;
    localparam int ROBW = 6;
    localparam int RING = 1 << (ROBW + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_redirect_arb_if #(.NBRU(NBRU), .ROBW(ROBW)) bus ();

    branch_redirect_arb #(.NBRU(NBRU), .ROBW(ROBW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: age is the forward distance around the ROB ring.
    function automatic bit m_older(input logic [ROBW:0] a, input logic [ROBW:0] b);
        int d;
        d = (int'(b) + RING - int'(a)) % RING;
        return d > 0 && d < RING / 2;
    endfunction

    bit            m_slot_vld;
    branchwbInfo_t m_slot;
    bit            m_bar_vld;
    logic [ROBW:0] m_bar_idx;
    bit            m_sq_vld;
    logic [ROBW:0] m_sq_idx;

    always @(posedge clk) begin
        int            best;
        logic [ROBW:0] c;
        bit            surv;
        bit            hs;
        if (rst) begin
            m_slot_vld = 0; m_slot = '0; m_bar_vld = 0; m_bar_idx = '0;
            m_sq_vld = 0; m_sq_idx = '0;
        end else begin
            best = -1;
            for (int p = 0; p < NBRU; p++)
                if (bus.i_branchwb_vld[p] &&
                    (best < 0 || m_older(bus.i_branchwbInfo[p].rob_idx, bus.i_branchwbInfo[best].rob_idx)))
                    best = p;
            c    = (best >= 0) ? bus.i_branchwbInfo[best].rob_idx : '0;
            surv = (best >= 0) && (!m_bar_vld || m_older(c, m_bar_idx));
            hs   = m_slot_vld && bus.i_redirect_rdy;
            m_sq_vld = 0;
            if (bus.i_flush) begin
                m_slot_vld = 0;
                m_bar_vld  = 0;
            end else if (surv && (!m_slot_vld || m_older(c, m_slot.rob_idx))) begin
                m_slot     = bus.i_branchwbInfo[best];
                m_slot_vld = 1;
                m_bar_vld  = 1;
                m_bar_idx  = c;
                m_sq_vld   = 1;
                m_sq_idx   = c;
            end else begin
                if (hs) m_slot_vld = 0;
                if (bus.i_commit_vld && bus.i_commit_rob_idx == m_bar_idx) m_bar_vld = 0;
            end
        end
    end

    // Continuous compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("redirect_vld", 128'(bus.o_redirect_vld), 128'(m_slot_vld));
            if (m_slot_vld)
                chk("redirect_info", 128'(bus.o_redirect_info), 128'(m_slot));
            chk("squash_vld", 128'(bus.o_squash_vld), 128'(m_sq_vld));
            if (m_sq_vld)
                chk("squash_idx", 128'(bus.o_squash_rob_idx), 128'(m_sq_idx));
        end
    end

    function automatic branchwbInfo_t mk(input logic [ROBW:0] rob, input logic [3:0] ftq, input logic [31:0] npc);
        branchwbInfo_t b;
        b                = '0;
        b.branch_type    = 3'd1;
        b.rob_idx        = rob;
        b.ftq_idx        = ftq;
        b.has_mispred    = 1'b1;
        b.branch_taken   = rob[0];
        b.fallthruOffset = rob[3:0];
        b.target_pc      = npc ^ 32'h0000_0f00;
        b.branch_npc     = npc;
        return b;
    endfunction

    task automatic setp(input int p, input logic [ROBW:0] rob, input logic [3:0] ftq, input logic [31:0] npc);
        bus.i_branchwb_vld[p] = 1'b1;
        bus.i_branchwbInfo[p] = mk(rob, ftq, npc);
    endtask

    task automatic quiet();
        bus.i_flush        = 1'b0;
        bus.i_branchwb_vld = '0;
        bus.i_commit_vld   = 1'b0;
    endtask

    task automatic commit(input logic [ROBW:0] idx);
        bus.i_commit_vld     = 1'b1;
        bus.i_commit_rob_idx = idx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        bus.i_redirect_rdy   = 1'b1;
        bus.i_commit_rob_idx = '0;
        for (int p = 0; p < NBRU; p++) bus.i_branchwbInfo[p] = '0;
        step(); step();
        chk("rst_redirect_vld", 128'(bus.o_redirect_vld), 128'd0);
        chk("rst_squash_vld", 128'(bus.o_squash_vld), 128'd0);
        chk("rst_info", 128'(bus.o_redirect_info), 128'd0);
        chk("rst_squash_idx", 128'(bus.o_squash_rob_idx), 128'd0);
        rst = 1'b0;
        step();

        // Single mispredict with ready high.
        setp(0, {1'b0, 6'd5}, 4'd2, 32'h8000_0100);
        step(); quiet();
        chk("single_vld", 128'(bus.o_redirect_vld), 128'd1);
        chk("single_npc", 128'(bus.o_redirect_info.branch_npc), 128'h8000_0100);
        chk("single_ftq", 128'(bus.o_redirect_info.ftq_idx), 128'd2);
        chk("single_sq", 128'(bus.o_squash_vld), 128'd1);
        chk("single_sq_idx", 128'(bus.o_squash_rob_idx), 128'd5);
        chk("model_bar_5", 128'(m_bar_idx), 128'd5);
        step();
        chk("single_done", 128'(bus.o_redirect_vld), 128'd0);
        commit({1'b0, 6'd5});
        step(); quiet();

        // Same-cycle arbitration under backpressure.
        bus.i_redirect_rdy = 1'b0;
        setp(0, {1'b0, 6'd9}, 4'd3, 32'h8000_0200);
        setp(1, {1'b0, 6'd4}, 4'd4, 32'h8000_0300);
        step(); quiet();
        chk("arb_slot", 128'(bus.o_redirect_info.rob_idx), 128'd4);
        chk("arb_sq_idx", 128'(bus.o_squash_rob_idx), 128'd4);
        step();
        chk("arb_one_squash", 128'(bus.o_squash_vld), 128'd0);
        bus.i_redirect_rdy = 1'b1;
        step();
        chk("arb_drain", 128'(bus.o_redirect_vld), 128'd0);
        commit({1'b0, 6'd4});
        step(); quiet();

        // Replacement under backpressure, then a younger one dropped.
        bus.i_redirect_rdy = 1'b0;
        setp(0, {1'b0, 6'd20}, 4'd5, 32'h8000_0400);
        step(); quiet();
        chk("repl_first", 128'(bus.o_redirect_info.rob_idx), 128'd20);
        setp(1, {1'b0, 6'd12}, 4'd6, 32'h8000_0500);
        step(); quiet();
        chk("repl_slot", 128'(bus.o_redirect_info.rob_idx), 128'd12);
        chk("repl_sq", 128'(bus.o_squash_vld), 128'd1);
        setp(0, {1'b0, 6'd30}, 4'd7, 32'h8000_0600);
        step(); quiet();
        chk("repl_drop_slot", 128'(bus.o_redirect_info.rob_idx), 128'd12);
        chk("repl_drop_sq", 128'(bus.o_squash_vld), 128'd0);

        // Barrier survives the handshake and clears on commit.
        bus.i_redirect_rdy = 1'b1;
        step();
        chk("bar_hs", 128'(bus.o_redirect_vld), 128'd0);
        setp(0, {1'b0, 6'd15}, 4'd8, 32'h8000_0700);
        step(); quiet();
        chk("bar_drop", 128'(bus.o_redirect_vld), 128'd0);
        chk("bar_drop_sq", 128'(bus.o_squash_vld), 128'd0);
        commit({1'b0, 6'd12});
        step(); quiet();
        chk("model_bar_clear", 128'(m_bar_vld), 128'd0);
        setp(0, {1'b0, 6'd15}, 4'd8, 32'h8000_0700);
        step(); quiet();
        chk("bar_accept", 128'(bus.o_redirect_vld), 128'd1);
        chk("bar_accept_idx", 128'(bus.o_squash_rob_idx), 128'd15);
        step();
        commit({1'b0, 6'd15});
        step(); quiet();

        // Wrap compare: {0,60} is older than {1,3}.
        bus.i_redirect_rdy = 1'b0;
        setp(0, {1'b1, 6'd3}, 4'd9, 32'h8000_0800);
        step(); quiet();
        chk("wrap_first", 128'(bus.o_redirect_info.rob_idx), 128'h43);
        setp(1, {1'b0, 6'd60}, 4'd10, 32'h8000_0900);
        step(); quiet();
        chk("wrap_slot", 128'(bus.o_redirect_info.rob_idx), 128'h3c);
        chk("wrap_sq", 128'(bus.o_squash_vld), 128'd1);
        chk("model_wrap", 128'(m_slot.rob_idx), 128'h3c);

        // Flush beats ready and a same-cycle older candidate.
        bus.i_redirect_rdy = 1'b1;
        bus.i_flush = 1'b1;
        setp(0, {1'b0, 6'd50}, 4'd11, 32'h8000_0a00);
        step(); quiet();
        chk("flush_vld", 128'(bus.o_redirect_vld), 128'd0);
        chk("flush_sq", 128'(bus.o_squash_vld), 128'd0);
        // {1,10} would be filtered by the old {0,60} barrier.
        bus.i_redirect_rdy = 1'b0;
        setp(0, {1'b1, 6'd10}, 4'd12, 32'h8000_0b00);
        step(); quiet();
        chk("flush_bar_clear", 128'(bus.o_redirect_vld), 128'd1);
        chk("flush_bar_idx", 128'(bus.o_squash_rob_idx), 128'h4a);

        // Reset while pending.
        rst = 1'b1;
        step();
        chk("rst_mid_vld", 128'(bus.o_redirect_vld), 128'd0);
        chk("rst_mid_sq", 128'(bus.o_squash_vld), 128'd0);
        rst = 1'b0;
        step(); step();
        chk("rst_mid_after", 128'(bus.o_redirect_vld), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
